// File: rtl/draw_scheduler_pkg.sv
// draw_scheduler_pkg
//   Shared definitions for the draw scheduler: FSM state encoding, requester
//   identifiers, default region dimensions, port widths and the round-robin
//   pick helper used by the arbiter.
package draw_scheduler_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_DRAW  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    typedef enum logic {
        REQ_SCREEN = 1'b0,
        REQ_SPRITE = 1'b1
    } req_id_t;

    localparam int DEF_SCREEN_W  = 160;
    localparam int DEF_SCREEN_H  = 120;
    localparam int DEF_SPRITE_W  = 40;
    localparam int DEF_SPRITE_H  = 40;

    localparam int X_W           = 8;
    localparam int Y_W           = 7;
    localparam int SCREEN_ADDR_W = 15;
    localparam int SPRITE_ADDR_W = 11;

    // A lone requester always wins; on a tie the one not served last wins.
    function automatic req_id_t rr_pick(input logic    screen_req,
                                        input logic    sprite_req,
                                        input req_id_t last_winner);
        if (screen_req && sprite_req)
            return (last_winner == REQ_SPRITE) ? REQ_SCREEN : REQ_SPRITE;
        else if (screen_req)
            return REQ_SCREEN;
        else
            return REQ_SPRITE;
    endfunction

endpackage

// File: rtl/draw_scheduler_raster_counter.sv
// raster_counter
//   Column/row/linear-address walker over a W x H region, column innermost.
//   Ports:
//     clk, rst      clock, synchronous active-high reset
//     clear         force col/row/addr to zero
//     advance       step to the next pixel (wraps to 0 after the last one)
//     col, row      current pixel position inside the region
//     addr          row*W+col of the current pixel
//     last          current pixel is (W-1, H-1)
module raster_counter
    import draw_scheduler_pkg::*;
#(
    parameter int W  = DEF_SPRITE_W,
    parameter int H  = DEF_SPRITE_H,
    parameter int AW = SPRITE_ADDR_W
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           clear,
    input  logic           advance,
    output logic [X_W-1:0] col,
    output logic [Y_W-1:0] row,
    output logic [AW-1:0]  addr,
    output logic           last
);

    localparam logic [X_W-1:0] COL_MAX = X_W'(W - 1);
    localparam logic [Y_W-1:0] ROW_MAX = Y_W'(H - 1);

    logic col_end;

    assign col_end = (col == COL_MAX);
    assign last    = col_end && (row == ROW_MAX);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            col  <= '0;
            row  <= '0;
            addr <= '0;
        end else if (advance) begin
            if (col_end) begin
                col <= '0;
                row <= (row == ROW_MAX) ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
            addr <= last ? '0 : addr + 1'b1;
        end
    end

endmodule

// File: rtl/draw_scheduler.sv
// draw_scheduler
//   Round-robin arbiter and raster sequencer sharing one VGA draw datapath
//   between a full-screen redraw and a sprite blit. A grant lasts from GRANT
//   through DONE; during DRAW one pixel per cycle is emitted with plot=1.
//   Ports:
//     clk                        clock
//     stateReset                 synchronous active-high reset
//     screenReq, spriteReq       level requests
//     spriteX, spriteY           sprite origin, latched at grant
//     screenGrant, spriteGrant   datapath ownership
//     screenDone, spriteDone     one-cycle completion pulses
//     x, y                       current pixel coordinate
//     screenAddress              screen ROM address (row*SCREEN_W+col)
//     spriteAddress              sprite ROM address (row*SPRITE_W+col)
//     plot                       pixel write strobe
//     busy                       scheduler is not idle
//   Configuration macro:
//     DRAW_SCHEDULER_CLIP_EN     suppress plot for pixels outside the screen
//                                (x>=SCREEN_W or y>=SCREEN_H); default build
//                                wraps x/y to port width and plots every pixel.
module draw_scheduler
    import draw_scheduler_pkg::*;
#(
    parameter int SCREEN_W = DEF_SCREEN_W,
    parameter int SCREEN_H = DEF_SCREEN_H,
    parameter int SPRITE_W = DEF_SPRITE_W,
    parameter int SPRITE_H = DEF_SPRITE_H
) (
    input  logic                     clk,
    input  logic                     stateReset,
    input  logic                     screenReq,
    input  logic                     spriteReq,
    input  logic [X_W-1:0]           spriteX,
    input  logic [Y_W-1:0]           spriteY,
    output logic                     screenGrant,
    output logic                     spriteGrant,
    output logic                     screenDone,
    output logic                     spriteDone,
    output logic [X_W-1:0]           x,
    output logic [Y_W-1:0]           y,
    output logic [SCREEN_ADDR_W-1:0] screenAddress,
    output logic [SPRITE_ADDR_W-1:0] spriteAddress,
    output logic                     plot,
    output logic                     busy
);

    state_t         state;
    req_id_t        winner;
    req_id_t        last_winner;
    req_id_t        pick;
    logic [X_W-1:0] origin_x;
    logic [Y_W-1:0] origin_y;
    logic           draw_last;

    logic start;
    logic step;

    logic [X_W-1:0]           scr_col, spr_col, cur_col;
    logic [Y_W-1:0]           scr_row, spr_row, cur_row;
    logic [SCREEN_ADDR_W-1:0] scr_addr;
    logic [SPRITE_ADDR_W-1:0] spr_addr;
    logic                     scr_last, spr_last, cur_last;

    logic [X_W-1:0] x_pix;
    logic [Y_W-1:0] y_pix;
    logic           visible;

    assign pick  = rr_pick(screenReq, spriteReq, last_winner);
    assign start = (state == S_IDLE) && (screenReq || spriteReq);
    // Counters hold the next pixel to emit: the GRANT edge emits pixel 0.
    assign step  = (state == S_GRANT) || ((state == S_DRAW) && !draw_last);

    raster_counter #(
        .W  (SCREEN_W),
        .H  (SCREEN_H),
        .AW (SCREEN_ADDR_W)
    ) u_screen_cnt (
        .clk     (clk),
        .rst     (stateReset),
        .clear   (start),
        .advance (step && (winner == REQ_SCREEN)),
        .col     (scr_col),
        .row     (scr_row),
        .addr    (scr_addr),
        .last    (scr_last)
    );

    raster_counter #(
        .W  (SPRITE_W),
        .H  (SPRITE_H),
        .AW (SPRITE_ADDR_W)
    ) u_sprite_cnt (
        .clk     (clk),
        .rst     (stateReset),
        .clear   (start),
        .advance (step && (winner == REQ_SPRITE)),
        .col     (spr_col),
        .row     (spr_row),
        .addr    (spr_addr),
        .last    (spr_last)
    );

    assign cur_col  = (winner == REQ_SCREEN) ? scr_col  : spr_col;
    assign cur_row  = (winner == REQ_SCREEN) ? scr_row  : spr_row;
    assign cur_last = (winner == REQ_SCREEN) ? scr_last : spr_last;

`ifdef DRAW_SCHEDULER_CLIP_EN
    logic [X_W:0] x_full;
    logic [Y_W:0] y_full;

    assign x_full  = {1'b0, origin_x} + {1'b0, cur_col};
    assign y_full  = {1'b0, origin_y} + {1'b0, cur_row};
    assign x_pix   = x_full[X_W-1:0];
    assign y_pix   = y_full[Y_W-1:0];
    assign visible = (x_full < (X_W+1)'(SCREEN_W)) &&
                     (y_full < (Y_W+1)'(SCREEN_H));
`else
    assign x_pix   = origin_x + cur_col;
    assign y_pix   = origin_y + cur_row;
    assign visible = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (stateReset) begin
            state         <= S_IDLE;
            winner        <= REQ_SCREEN;
            last_winner   <= REQ_SPRITE;
            origin_x      <= '0;
            origin_y      <= '0;
            draw_last     <= 1'b0;
            screenGrant   <= 1'b0;
            spriteGrant   <= 1'b0;
            screenDone    <= 1'b0;
            spriteDone    <= 1'b0;
            x             <= '0;
            y             <= '0;
            screenAddress <= '0;
            spriteAddress <= '0;
            plot          <= 1'b0;
            busy          <= 1'b0;
        end else begin
            screenDone <= 1'b0;
            spriteDone <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state         <= S_GRANT;
                        busy          <= 1'b1;
                        winner        <= pick;
                        last_winner   <= pick;
                        origin_x      <= (pick == REQ_SCREEN) ? '0 : spriteX;
                        origin_y      <= (pick == REQ_SCREEN) ? '0 : spriteY;
                        screenGrant   <= (pick == REQ_SCREEN);
                        spriteGrant   <= (pick == REQ_SPRITE);
                        screenAddress <= '0;
                        spriteAddress <= '0;
                    end
                end
                S_GRANT, S_DRAW: begin
                    if ((state == S_DRAW) && draw_last) begin
                        state      <= S_DONE;
                        plot       <= 1'b0;
                        screenDone <= (winner == REQ_SCREEN);
                        spriteDone <= (winner == REQ_SPRITE);
                    end else begin
                        state     <= S_DRAW;
                        x         <= x_pix;
                        y         <= y_pix;
                        plot      <= visible;
                        draw_last <= cur_last;
                        if (winner == REQ_SCREEN)
                            screenAddress <= scr_addr;
                        else
                            spriteAddress <= spr_addr;
                    end
                end
                S_DONE: begin
                    state       <= S_IDLE;
                    screenGrant <= 1'b0;
                    spriteGrant <= 1'b0;
                    busy        <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_draw_scheduler.sv
module tb_draw_scheduler;

    logic        clk = 1'b0;
    logic        stateReset;
    logic        screenReq;
    logic        spriteReq;
    logic [7:0]  spriteX;
    logic [6:0]  spriteY;
    logic        screenGrant, spriteGrant;
    logic        screenDone, spriteDone;
    logic [7:0]  x;
    logic [6:0]  y;
    logic [14:0] screenAddress;
    logic [10:0] spriteAddress;
    logic        plot;
    logic        busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    draw_scheduler dut (
        .clk           (clk),
        .stateReset    (stateReset),
        .screenReq     (screenReq),
        .spriteReq     (spriteReq),
        .spriteX       (spriteX),
        .spriteY       (spriteY),
        .screenGrant   (screenGrant),
        .spriteGrant   (spriteGrant),
        .screenDone    (screenDone),
        .spriteDone    (spriteDone),
        .x             (x),
        .y             (y),
        .screenAddress (screenAddress),
        .spriteAddress (spriteAddress),
        .plot          (plot),
        .busy          (busy)
    );

    // Reference: a scr/sprite region of w x h pixels anchored at (ox,oy).
    // Pixel k sits at col=k%w, row=k/w; coordinates wrap at 256/128 and,
    // with clipping, only pixels inside the 160x120 screen are plotted.
    function automatic bit model_plot(input int xf, input int yf);
`ifdef DRAW_SCHEDULER_CLIP_EN
        return (xf < 160) && (yf < 120);
`else
        return 1'b1;
`endif
    endfunction

    task automatic do_draw(input bit scr, input int ox, input int oy,
                           input bit drop, input bit scramble,
                           output int waits);
        int w, h, bad, bad_k, plots, exp_plots;
        int col, row, xf, yf, lx, ly, la, obs_a;
        bit ep;
        w = scr ? 160 : 40;
        h = scr ? 120 : 40;
        waits = 0;
        do begin
            @(negedge clk);
            waits++;
        end while (!(screenGrant || spriteGrant) && waits < 8);
        checks++;
        assert (waits < 8) else begin
            errors++;
            $error("FAIL grant_timeout obs waits=%0d exp <8", waits);
        end
        if (waits >= 8) return;
        checks++;
        assert ({screenGrant, spriteGrant, plot, busy} === {scr, !scr, 1'b0, 1'b1})
        else begin
            errors++;
            $error("FAIL grant_cycle obs sg=%b pg=%b plot=%b busy=%b exp scr=%b",
                   screenGrant, spriteGrant, plot, busy, scr);
        end
        if (drop) begin
            screenReq = 1'b0;
            spriteReq = 1'b0;
        end
        bad = 0; bad_k = -1; plots = 0; exp_plots = 0;
        lx = 0; ly = 0; la = 0;
        for (int k = 0; k < w * h; k++) begin
            @(negedge clk);
            if (scramble) begin
                spriteX = 8'($urandom);
                spriteY = 7'($urandom);
            end
            col = k % w;
            row = k / w;
            xf  = ox + col;
            yf  = oy + row;
            ep  = model_plot(xf, yf);
            lx  = xf % 256;
            ly  = yf % 128;
            la  = k;
            obs_a = scr ? int'(screenAddress) : int'(spriteAddress);
            if (ep) exp_plots++;
            if (plot) plots++;
            if (plot !== ep || int'(x) !== lx || int'(y) !== ly || obs_a !== k ||
                (scr ? spriteAddress !== 11'd0 : screenAddress !== 15'd0) ||
                screenGrant !== scr || spriteGrant !== !scr || busy !== 1'b1 ||
                screenDone !== 1'b0 || spriteDone !== 1'b0) begin
                if (bad == 0) bad_k = k;
                bad++;
            end
        end
        checks++;
        assert (bad === 0) else begin
            errors++;
            $error("FAIL pixel_stream obs %0d bad pixels (first k=%0d) exp 0",
                   bad, bad_k);
        end
        checks++;
        assert (plots === exp_plots) else begin
            errors++;
            $error("FAIL plot_count obs %0d exp %0d", plots, exp_plots);
        end
        @(negedge clk);
        obs_a = scr ? int'(screenAddress) : int'(spriteAddress);
        checks++;
        assert ({screenDone, spriteDone, plot, screenGrant, spriteGrant} ===
                {scr, !scr, 1'b0, scr, !scr} &&
                int'(x) === lx && int'(y) === ly && obs_a === la)
        else begin
            errors++;
            $error("FAIL done_cycle obs sd=%b pd=%b plot=%b x=%0d y=%0d a=%0d exp x=%0d y=%0d a=%0d",
                   screenDone, spriteDone, plot, x, y, obs_a, lx, ly, la);
        end
        @(negedge clk);
        obs_a = scr ? int'(screenAddress) : int'(spriteAddress);
        checks++;
        assert ({screenDone, spriteDone, plot, screenGrant, spriteGrant, busy} === 6'b0 &&
                int'(x) === lx && int'(y) === ly && obs_a === la)
        else begin
            errors++;
            $error("FAIL idle_after obs sd=%b pd=%b plot=%b grants=%b%b busy=%b x=%0d y=%0d a=%0d",
                   screenDone, spriteDone, plot, screenGrant, spriteGrant, busy, x, y, obs_a);
        end
    endtask

    initial begin
        int w1, w2, ox, oy, cnt, waits;
        bit saw_done;
        stateReset = 1'b1;
        screenReq  = 1'b0;
        spriteReq  = 1'b0;
        spriteX    = 8'd0;
        spriteY    = 7'd0;
        repeat (2) @(negedge clk);
        checks++;
        assert ({screenGrant, spriteGrant, screenDone, spriteDone, plot, busy} === 6'b0 &&
                x === 8'd0 && y === 7'd0 && screenAddress === 15'd0 &&
                spriteAddress === 11'd0)
        else begin
            errors++;
            $error("FAIL reset_state obs grants=%b%b plot=%b busy=%b x=%0d y=%0d exp all 0",
                   screenGrant, spriteGrant, plot, busy, x, y);
        end

        // Tie from reset: screen first, then sprite with a 3-cycle plot gap.
        screenReq = 1'b1;
        spriteReq = 1'b1;
        spriteX   = 8'd12;
        spriteY   = 7'd34;
        @(negedge clk);
        stateReset = 1'b0;
        do_draw(1'b1, 0, 0, 1'b0, 1'b0, w1);
        checks++;
        assert (w1 === 1) else begin
            errors++;
            $error("FAIL tie_first_latency obs %0d exp 1", w1);
        end
        do_draw(1'b0, 12, 34, 1'b1, 1'b0, w2);
        checks++;
        assert (w2 === 1) else begin
            errors++;
            $error("FAIL tie_gap obs %0d exp 1", w2);
        end

        // One-cycle screen request pulse.
        screenReq = 1'b1;
        do_draw(1'b1, 0, 0, 1'b1, 1'b0, w1);

        // Screen served last, so a tie now goes to the sprite.
        spriteX   = 8'd5;
        spriteY   = 7'd6;
        screenReq = 1'b1;
        spriteReq = 1'b1;
        do_draw(1'b0, 5, 6, 1'b1, 1'b1, w1);

        // Directed sprite origins, including off-screen/wrapping, with
        // origin inputs scrambled mid-draw.
        spriteX = 8'd100; spriteY = 7'd50; spriteReq = 1'b1;
        do_draw(1'b0, 100, 50, 1'b1, 1'b1, w1);
        spriteX = 8'd150; spriteY = 7'd110; spriteReq = 1'b1;
        do_draw(1'b0, 150, 110, 1'b1, 1'b1, w1);

        for (int i = 0; i < 3; i++) begin
            ox = $urandom_range(0, 255);
            oy = $urandom_range(0, 127);
            spriteX = 8'(ox); spriteY = 7'(oy); spriteReq = 1'b1;
            do_draw(1'b0, ox, oy, 1'b1, 1'b1, w1);
        end

        // Reset at the 500th sprite pixel aborts the draw.
        spriteX = 8'd20; spriteY = 7'd30; spriteReq = 1'b1;
        waits = 0;
        do begin
            @(negedge clk);
            waits++;
        end while (!spriteGrant && waits < 8);
        checks++;
        assert (spriteGrant === 1'b1) else begin
            errors++;
            $error("FAIL abort_grant obs %b exp 1", spriteGrant);
        end
        spriteReq = 1'b0;
        cnt = 0;
        for (int k = 0; k < 500; k++) begin
            @(negedge clk);
            if (plot) cnt++;
        end
        checks++;
        assert (cnt === 500 && spriteAddress === 11'd499) else begin
            errors++;
            $error("FAIL abort_progress obs plots=%0d addr=%0d exp 500/499",
                   cnt, spriteAddress);
        end
        stateReset = 1'b1;
        @(negedge clk);
        checks++;
        assert ({plot, busy, spriteGrant, spriteDone} === 4'b0 &&
                spriteAddress === 11'd0 && x === 8'd0 && y === 7'd0)
        else begin
            errors++;
            $error("FAIL abort_reset obs plot=%b busy=%b pg=%b pd=%b a=%0d x=%0d",
                   plot, busy, spriteGrant, spriteDone, spriteAddress, x);
        end
        stateReset = 1'b0;
        saw_done = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (spriteDone || plot || busy) saw_done = 1'b1;
        end
        checks++;
        assert (saw_done === 1'b0) else begin
            errors++;
            $error("FAIL abort_quiet obs activity=%b exp 0", saw_done);
        end
        spriteX = 8'd70; spriteY = 7'd9; spriteReq = 1'b1;
        do_draw(1'b0, 70, 9, 1'b1, 1'b0, w1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/draw_scheduler.md
DRAW_SCHEDULER -- requirements
Module: draw_scheduler

Interface
REQ-001 Parameter SCREEN_W, default 160: width of the screen region in pixels.
REQ-002 Parameter SCREEN_H, default 120: height of the screen region in pixels.
REQ-003 Parameter SPRITE_W, default 40: width of the sprite region in pixels.
REQ-004 Parameter SPRITE_H, default 40: height of the sprite region in pixels.
REQ-005 clk  in  1  sole clock; all state changes on its rising edge.
REQ-006 stateReset  in  1  reset, synchronous, active-high.
REQ-007 screenReq  in  1  level request to draw the full screen region with origin (0,0).
REQ-008 spriteReq  in  1  level request to draw one sprite region.
REQ-009 spriteX  in  8  sprite origin x, sampled at grant.
REQ-010 spriteY  in  7  sprite origin y, sampled at grant.
REQ-011 screenGrant, spriteGrant  out  1 each  requester owns the draw datapath.
REQ-012 screenDone, spriteDone  out  1 each  one-cycle completion pulse.
REQ-013 x  out  8,  y  out  7  current VGA pixel coordinate.
REQ-014 screenAddress  out  15  screen ROM address, row*SCREEN_W+col.
REQ-015 spriteAddress  out  11  sprite ROM address, row*SPRITE_W+col.
REQ-016 plot  out  1  pixel write strobe; busy  out  1  state is not IDLE.

Function
REQ-017 FSM states: IDLE, GRANT, DRAW, DONE.
REQ-018 IDLE: with any request, go to GRANT next edge; otherwise stay.
REQ-019 Arbitration is round-robin between the two requesters; a lone requester always wins.
REQ-020 When both requesters are active in IDLE, the requester not granted last wins.
REQ-021 GRANT lasts one cycle: latch the winner and the origin, clear col/row/address, assert the winner's grant.
REQ-022 DRAW: one pixel per cycle with plot=1; x=originX+col, y=originY+row; col is the inner loop and row the outer.
REQ-023 The address increments by 1 every DRAW cycle, from 0 to W*H-1 of the granted region.
REQ-024 After the pixel at col=W-1 and row=H-1, go to DONE; DONE lasts one cycle, pulses the winner's done, then goes to IDLE.
REQ-025 The grant stays high from GRANT through DONE inclusive and is low in IDLE.
REQ-026 Latency: a request seen in IDLE at edge N gives the first plot in cycle N+2 and done in cycle N+2+W*H.
REQ-027 Once granted, request deassertion is ignored and the draw completes.
REQ-028 A request still high in the IDLE that follows DONE is re-arbitrated normally.
REQ-029 Origin inputs that change during DRAW have no effect.
REQ-030 In IDLE, GRANT and DONE: plot=0, and x, y and both addresses hold their last values.
REQ-031 The address of the non-granted requester is held at 0.

Reset
REQ-032 When stateReset=1 at an edge: state=IDLE; x, y, both addresses, plot, both grants, both dones and busy=0; round-robin pointer=sprite, so the screen wins the first tie.
REQ-033 Reset during DRAW aborts the draw: no done pulse, and plot is low from the next cycle.

Configuration
REQ-034 Macro DRAW_SCHEDULER_CLIP_EN defined: plot=0 for any pixel with x>=SCREEN_W or y>=SCREEN_H; addresses and the cycle count are unchanged.
REQ-035 Macro undefined: x and y are truncated to port width (wrap-around), and plot=1 for every DRAW cycle.

Structure
REQ-036 A shared package holds the state encoding, the requester-ID enum and the default dimension constants.
REQ-037 One sub-module, raster_counter, holds col/row/address and the last-pixel flag, parameterised by W and H; two instances or one width-muxed instance are both allowed.

Verification
REQ-038 screenReq pulse held 1 cycle -> screenGrant 19202 cycles; 19200 plots; final x=159, y=119, screenAddress=19199; screenDone once.
REQ-039 spriteReq with (100,50) -> first plot x=100, y=50, addr 0; last plot x=139, y=89, addr 1599; 1600 plots.
REQ-040 Both requests high from reset -> screen served first, then sprite; no plot gap beyond the DONE/IDLE/GRANT cycles.
REQ-041 spriteReq with (150,110) -> clip macro on: plots only where x<160 and y<120 (100 plots); macro off: 1600 plots, with y wrapping at 128.
REQ-042 stateReset asserted at the 500th sprite pixel -> next cycle IDLE, plot=0, no spriteDone; a new spriteReq restarts at addr 0.
REQ-043 spriteX changed mid-DRAW -> the x sequence is unaffected.
